fetch_block: RTL and testbench

FETCH_BLOCK -- requirements
Module: fetch_block

---
 rtl/fetch_block.sv | 107 ++++++++++
 tb/tb_fetch_block.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_block.sv
// Instruction fetch controller: issues one memory request per instruction,
// holds the fetched word for decode and steers the PC on redirects.
module fetch_block #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] curr_addr,
    output logic [31:0] next_addr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] inst_nxt, inst_pc_nxt;
    logic        inst_valid_nxt;
    logic [31:0] target;

    assign target = redirect_addr & 32'hFFFF_FFFC;

    always_comb begin
        state_nxt      = state;
        next_addr      = curr_addr;
        imem_req       = 1'b0;
        imem_addr      = 32'h0;
        inst_valid_nxt = inst_valid;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        drop_addr_nxt  = drop_addr;
        if (rst) begin
            next_addr = RESET_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FETCH;
                    if (redirect_valid) begin
                        next_addr      = target;
                        inst_valid_nxt = 1'b0;
                    end
                end
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = curr_addr;
                    if (redirect_valid) begin
                        next_addr = target;
                        // An unacked request must still complete; park it in DROP.
                        if (!imem_ack) begin
                            drop_addr_nxt = curr_addr;
                            state_nxt     = DROP;
                        end
                    end else if (imem_ack) begin
                        inst_nxt       = imem_rdata;
                        inst_pc_nxt    = curr_addr;
                        inst_valid_nxt = 1'b1;
                        next_addr      = curr_addr + 32'd4;
                        state_nxt      = HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        next_addr      = target;
                        inst_valid_nxt = 1'b0;
                        state_nxt      = FETCH;
                    end else if (inst_ready) begin
                        inst_valid_nxt = 1'b0;
                        state_nxt      = FETCH;
                    end
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr;
                    if (redirect_valid) next_addr = target;
                    if (imem_ack) state_nxt = FETCH;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            drop_addr  <= 32'h0;
        end else begin
            state      <= state_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            drop_addr  <= drop_addr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_block.sv
// Bench for fetch_block: the bench plays pc_block from its own model PC and
// checks every output each cycle against a flag-based behavioural model.
module tb_fetch_block;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_addr;
    logic [31:0] next_addr;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    localparam logic [31:0] RA = 32'h0000_0000;

    fetch_block #(.RESET_ADDR(RA)) dut (
        .clk(clk), .rst(rst), .curr_addr(curr_addr), .next_addr(next_addr),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: PC register, cycles since reset, held instruction, pending drop.
    logic [31:0] m_pc = 32'h0;
    int          m_age = 0;
    logic        m_have = 1'b0;
    logic [31:0] m_inst = 32'h0, m_inst_pc = 32'h0;
    logic        m_drop = 1'b0;
    logic [31:0] m_drop_addr = 32'h0;

    // Last sampled DUT outputs, for literal checks.
    logic        d_req, d_valid;
    logic [31:0] d_addr, d_next, d_inst, d_pc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] ra,
                        input logic ack, input logic [31:0] rd, input logic rdy);
        logic [31:0] tgt, e_next, e_addr;
        logic        e_req;
        rst = r; redirect_valid = rv; redirect_addr = ra;
        imem_ack = ack; imem_rdata = rd; inst_ready = rdy; curr_addr = m_pc;
        @(negedge clk);
        tgt = {ra[31:2], 2'b00};
        if (r) begin
            e_req = 1'b0; e_addr = 32'h0; e_next = RA;
        end else if (m_drop) begin
            e_req = 1'b1; e_addr = m_drop_addr; e_next = rv ? tgt : m_pc;
        end else if (m_age == 0 || m_have) begin
            e_req = 1'b0; e_addr = 32'h0; e_next = rv ? tgt : m_pc;
        end else begin
            e_req = 1'b1; e_addr = m_pc;
            e_next = rv ? tgt : (ack ? m_pc + 32'd4 : m_pc);
        end
        chk("next_addr", next_addr, e_next);
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("imem_addr", imem_addr, e_addr);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_inst_pc);
        d_req = imem_req; d_addr = imem_addr; d_next = next_addr;
        d_valid = inst_valid; d_inst = inst; d_pc = inst_pc;
        if (r) begin
            m_age = 0; m_have = 1'b0; m_inst = 32'h0; m_inst_pc = 32'h0;
            m_drop = 1'b0; m_drop_addr = 32'h0;
        end else begin
            if (m_drop) begin
                if (ack) m_drop = 1'b0;
            end else if (m_age == 0) begin
                // first cycle after reset issues nothing
            end else if (m_have) begin
                if (rv || rdy) m_have = 1'b0;
            end else if (rv) begin
                if (!ack) begin m_drop = 1'b1; m_drop_addr = m_pc; end
            end else if (ack) begin
                m_have = 1'b1; m_inst = rd; m_inst_pc = m_pc;
            end
            if (m_age < 1000) m_age++;
        end
        m_pc = e_next;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 32'h0; imem_ack = 1'b0;
        imem_rdata = 32'h0; inst_ready = 1'b0; curr_addr = 32'h0;
        @(posedge clk); #1;
        step(1, 0, 0, 1, 32'hBAD0_0001, 1);
        chk("rst_next", d_next, RA);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, d_valid}, 32'h0);

        // Zero-wait stream 0,4,8
        step(0, 0, 0, 1, 32'hBAD0_0002, 1);
        chk("idle_req", {31'b0, d_req}, 32'h0);
        step(0, 0, 0, 1, 32'hA000_0000, 1);
        chk("f0_addr", d_addr, 32'h0);
        chk("f0_next", d_next, 32'h4);
        step(0, 0, 0, 0, 0, 1);
        chk("h0_pc", d_pc, 32'h0);
        chk("h0_inst", d_inst, 32'hA000_0000);
        step(0, 0, 0, 1, 32'hA000_0004, 1);
        chk("f1_addr", d_addr, 32'h4);
        step(0, 0, 0, 0, 0, 1);
        chk("h1_pc", d_pc, 32'h4);
        step(0, 0, 0, 1, 32'hA000_0008, 1);
        chk("f2_addr", d_addr, 32'h8);
        // Redirect from HOLD to 0x10 (even with inst_ready=1)
        step(0, 1, 32'h10, 0, 0, 1);
        chk("h2_pc", d_pc, 32'h8);
        chk("h2_inst", d_inst, 32'hA000_0008);

        // Ack delayed 3 cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 32'hDEAD_0000, 1);
            chk("wait_addr", d_addr, 32'h10);
            chk("wait_next", d_next, 32'h10);
        end
        step(0, 0, 0, 1, 32'h0000_0013, 0);
        chk("ack_addr", d_addr, 32'h10);
        chk("ack_next", d_next, 32'h14);

        // Decode stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 32'hDEAD_0001, 0);
            chk("stall_inst", d_inst, 32'h0000_0013);
            chk("stall_pc", d_pc, 32'h10);
            chk("stall_req", {31'b0, d_req}, 32'h0);
            chk("stall_next", d_next, 32'h14);
        end

        // Redirect during unacked FETCH -> DROP
        step(0, 1, 32'h1110, 0, 0, 0);
        step(0, 1, 32'h4446, 0, 0, 0);
        chk("rd_addr", d_addr, 32'h1110);
        chk("rd_next", d_next, 32'h4444);
        step(0, 0, 0, 0, 0, 1);
        chk("drop_addr", d_addr, 32'h1110);
        chk("drop_next", d_next, 32'h4444);
        step(0, 0, 0, 1, 32'hDEAD_DEAD, 1);
        chk("drop_ack_addr", d_addr, 32'h1110);
        step(0, 0, 0, 1, 32'h0000_0055, 1);
        chk("post_drop_addr", d_addr, 32'h4444);
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 1);
        chk("post_drop_inst", d_inst, 32'h0000_0055);

        // Wrap at top of address space
        step(0, 0, 0, 1, 32'h0000_0077, 1);
        chk("wrap_next", d_next, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_pc", d_pc, 32'hFFFF_FFFC);

        // Reset during FETCH with concurrent ack
        step(1, 0, 0, 1, 32'hBAD0_0003, 1);
        chk("rst_fetch_next", d_next, RA);
        chk("rst_fetch_req", {31'b0, d_req}, 32'h0);
        step(0, 0, 0, 1, 32'hBAD0_0004, 1);
        chk("rst_fetch_valid", {31'b0, d_valid}, 32'h0);
        chk("rst_fetch_idle", {31'b0, d_req}, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 15), $urandom,
                 ($urandom_range(99) < 50), $urandom, ($urandom_range(99) < 60));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
